// File: rtl/cgra_conf_mux.sv
// cgra_conf_mux: run-time configurable N-to-1 selector for CGRA interconnect.
// The select value is staged in a shadow register over the config bus and
// moved into the active select on a global commit strobe. The selected
// data/valid then passes through PIPE stallable register stages.
module cgra_conf_mux #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NINPUTS = 7,
  parameter int unsigned SEL_W   = $clog2(NINPUTS),
  parameter int unsigned PIPE    = 1,
  parameter logic [7:0]  CONF_ID = 8'h00
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       conf_valid,
  input  logic [7:0]                 conf_id,
  input  logic [7:0]                 conf_sel,
  input  logic                       conf_commit,
  input  logic [NINPUTS*WIDTH-1:0]   in_data,
  input  logic [NINPUTS-1:0]         in_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  output logic                       sel_err
);

  logic [SEL_W-1:0] r_shadow;
  logic [SEL_W-1:0] r_active;
  logic             r_sel_err;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_valid;
  logic             w_oor;

  // Upper conf_sel bits are ignored, and en is irrelevant when PIPE=0.
  logic [8:0]       w_unused;
  assign w_unused = {en, conf_sel};

  // Shadow captures addressed writes; commit copies the pre-write shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (conf_commit) r_active <= r_shadow;
      if (conf_valid && (conf_id == CONF_ID)) r_shadow <= conf_sel[SEL_W-1:0];
    end
  end

  assign w_oor = (32'(r_active) >= NINPUTS);

  // Out-of-range select flag, registered every cycle regardless of en.
  always_ff @(posedge clk) begin
    if (rst) r_sel_err <= 1'b0;
    else     r_sel_err <= w_oor;
  end

  assign sel_err = r_sel_err;

  // Selection stage: unmatched (out-of-range) selects yield zero data/valid.
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    for (int unsigned k = 0; k < NINPUTS; k++) begin
      if (32'(r_active) == k) begin
        w_sel_data  = in_data[k*WIDTH +: WIDTH];
        w_sel_valid = in_valid[k];
      end
    end
  end

  generate
    if (PIPE == 0) begin : g_comb
      assign out_data  = w_sel_data;
      assign out_valid = w_sel_valid;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_pd [PIPE];
      logic             r_pv [PIPE];

      // Output pipeline: all stages advance together on en, hold otherwise.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned s = 0; s < PIPE; s++) begin
            r_pd[s] <= '0;
            r_pv[s] <= 1'b0;
          end
        end else if (en) begin
          r_pd[0] <= w_sel_data;
          r_pv[0] <= w_sel_valid;
          for (int unsigned s = 1; s < PIPE; s++) begin
            r_pd[s] <= r_pd[s-1];
            r_pv[s] <= r_pv[s-1];
          end
        end
      end

      assign out_data  = r_pd[PIPE-1];
      assign out_valid = r_pv[PIPE-1];
    end
  endgenerate

endmodule
